// File: rtl/rs232_pkg.sv
// Shared RS232 definitions for the FPGA-side receiver and transmitter:
// bit timing at 9600 baud from 50 MHz, frame width and FSM state encodings.
package rs232_pkg;

    localparam int unsigned DIVIDER   = 5208;
    localparam int unsigned HALF_DIV  = DIVIDER / 2;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned CNT_W     = 13;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

endpackage

// File: rtl/rs232_sync2.sv
// Two-flop synchronizer for an asynchronous level input; both stages reset to
// a configurable value so an idle-high line never shows a false edge.
module rs232_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/rs232_fpga_rx.sv
// 8N1 UART receiver: centre-samples each bit, holds the last good byte with a
// valid/ack handshake, pulses frame_err on a low stop bit and flags overruns.
module rs232_fpga_rx
    import rs232_pkg::*;
#(
    parameter int unsigned P_DIVIDER = DIVIDER
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    input  logic                 i_rx_ack,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_overrun,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam logic [CNT_W-1:0] L_DIV_LAST  = CNT_W'(P_DIVIDER - 1);
    localparam logic [CNT_W-1:0] L_HALF_LAST = CNT_W'(P_DIVIDER / 2 - 1);
    localparam logic [2:0]       L_LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_overrun;
    logic                 r_frame_err;

    rs232_sync2 #(.RST_VAL(1'b1)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (i_rx_ack && r_rx_valid) begin
                r_rx_valid <= 1'b0;
                r_overrun  <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) r_state <= START;
                end
                START: begin
                    if (r_cnt == L_HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == L_DIV_LAST) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        if (r_bit_idx == L_LAST_BIT) r_state <= STOP;
                        else                         r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == L_DIV_LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            // A load in the same cycle as an ack wins: the byte
                            // is fresh and any earlier overrun is forgiven.
                            r_state    <= IDLE;
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                            if (i_rx_ack && r_rx_valid) r_overrun <= 1'b0;
                            else                        r_overrun <= r_overrun | r_rx_valid;
                        end else begin
                            r_state     <= WAIT_HIGH;
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    r_cnt <= '0;
                    if (w_rx_s) r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_overrun   = r_overrun;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_rs232_fpga_rx.sv
// Randomized and directed bench for rs232_fpga_rx with a frame-level reference
// model; runs at a reduced bit divider so every scenario fits a short run.
module tb_rs232_fpga_rx;

    localparam int DIV  = 32;
    localparam int HALF = DIV / 2;
    localparam int LAT  = HALF + 9 * DIV + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, overrun, frame_err, busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int busy_cnt = 0;
    int rise_cyc = -1;
    int fall_cyc = 0;
    logic prev_valid = 1'b0;

    logic [7:0] exp_data = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ovr = 1'b0;
    int         exp_fe = 0;

    rs232_fpga_rx #(.P_DIVIDER(DIV)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .i_rx_ack    (ack),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .o_overrun   (overrun),
        .o_frame_err (frame_err),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded cycle budget at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; leaves the line at the stop level one bit later.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        rx = 1'b0;
        fall_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            idle(DIV);
            rx = b[i];
        end
        idle(DIV);
        rx = stop_lvl;
        idle(DIV);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        idle(1);
        ack = 1'b0;
        if (exp_valid) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
        end
    endtask

    function automatic void model_load(input logic [7:0] b, input logic acked);
        if (exp_valid && !acked) exp_ovr = 1'b1;
        else                     exp_ovr = 1'b0;
        exp_valid = 1'b1;
        exp_data  = b;
    endfunction

    task automatic check_state(input string tag);
        chk_eq({tag, "_data"},  32'(rx_data),  32'(exp_data));
        chk_eq({tag, "_valid"}, 32'(rx_valid), 32'(exp_valid));
        chk_eq({tag, "_ovr"},   32'(overrun),  32'(exp_ovr));
        chk_eq({tag, "_fe"},    32'(fe_cnt),   32'(exp_fe));
    endtask

    initial begin
        int d;
        logic [7:0] b;
        logic st;

        idle(3);
        rst = 1'b0;
        idle(2);
        check_state("reset");
        chk_eq("reset_busy", 32'(busy), 32'd0);

        // Clean A5 frame and latency from the pin edge.
        send_frame(8'hA5, 1'b1);
        model_load(8'hA5, 1'b0);
        idle(4);
        check_state("a5");
        chk_eq("a5_busy", 32'(busy), 32'd0);
        d = rise_cyc - fall_cyc;
        chk_eq("a5_latency", (d >= LAT - 1 && d <= LAT + 1) ? 32'(LAT) : 32'(d), 32'(LAT));
        pulse_ack();
        idle(1);
        check_state("a5_ack");

        // Short low glitch: rejected at the mid-start check.
        busy_cnt = 0;
        rx = 1'b0;
        idle(6);
        rx = 1'b1;
        idle(2 * DIV);
        check_state("glitch");
        chk_eq("glitch_busy", (busy_cnt >= HALF - 1 && busy_cnt <= HALF + 1) ? 32'(HALF) : 32'(busy_cnt), 32'(HALF));

        // Low stop bit followed by a long break.
        send_frame(8'h3C, 1'b0);
        exp_fe = exp_fe + 1;
        idle(20 * DIV);
        chk_eq("break_busy_held", 32'(busy), 32'd1);
        rx = 1'b1;
        idle(5);
        check_state("break");
        chk_eq("break_busy_rel", 32'(busy), 32'd0);

        // Back-to-back frames without ack give an overrun.
        send_frame(8'h11, 1'b1);
        model_load(8'h11, 1'b0);
        send_frame(8'h22, 1'b1);
        model_load(8'h22, 1'b0);
        idle(2);
        check_state("b2b");
        pulse_ack();
        idle(1);
        check_state("b2b_ack");

        // Ack lands in the same cycle as the next load.
        send_frame(8'h11, 1'b1);
        model_load(8'h11, 1'b0);
        fork
            send_frame(8'h55, 1'b1);
            begin
                idle(LAT - 1);
                ack = 1'b1;
                idle(1);
                ack = 1'b0;
            end
        join
        model_load(8'h55, 1'b1);
        idle(2);
        check_state("ack_load");
        pulse_ack();
        idle(1);

        // Reset in the middle of data bit 4, then a clean frame.
        fork
            send_frame(8'hFF, 1'b1);
            begin
                idle(5 * DIV + HALF);
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
                exp_data = 8'h00; exp_valid = 1'b0; exp_ovr = 1'b0;
                check_state("mid_rst");
                chk_eq("mid_rst_busy", 32'(busy), 32'd0);
            end
        join
        idle(DIV);
        check_state("post_rst");
        send_frame(8'h0F, 1'b1);
        model_load(8'h0F, 1'b0);
        idle(4);
        check_state("rst_0f");

        // Random frames, random stop validity, random acks between frames.
        for (int k = 0; k < 10; k++) begin
            b  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) pulse_ack();
            send_frame(b, st);
            if (st) begin
                model_load(b, 1'b0);
            end else begin
                exp_fe = exp_fe + 1;
                rx = 1'b1;
            end
            idle(2 * DIV);
            check_state($sformatf("rnd%0d", k));
            chk_eq($sformatf("rnd%0d_busy", k), 32'(busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rs232_fpga_rx.md
Name: rs232_fpga_rx

Overview:
- UART receiver for the PC-to-FPGA direction of the RS232 link. It is the companion to the FPGA-side transmitter.
- Deserialises 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) at 9600 baud from a 50 MHz clock.
- Presents each received byte in a holding register with a valid/ack handshake to downstream logic (LEDs, loopback, command decoder).
- Reports framing errors and overruns.

Parameters:
- DIVIDER, 5208, clock cycles per bit (50 MHz / 9600); 13-bit quantity.
- HALF_DIV, 2604, cycles from the start-bit edge to mid-start-bit sample (DIVIDER/2).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- rx  in  1  serial line from PC; asynchronous; idles high
- rx_ack  in  1  downstream consumed rx_data; single-cycle pulse
- rx_data  out  8  last good received byte
- rx_valid  out  1  rx_data holds an unconsumed byte (level)
- overrun  out  1  sticky: a byte was overwritten before being acked
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- busy  out  1  high in any state other than IDLE

Behaviour:
- Input sync: rx passes through 2 flops (rx_s). Both flops reset to 1. All FSM decisions use rx_s only.
- Counter: tick counter cnt is 13 bits. It clears on every state change and on every bit sample. A bit index bit_idx (3 bits) tracks data bits.
- IDLE: cnt = 0, busy = 0. When rx_s == 0, go to START.
- START: cnt increments each cycle. At cnt == HALF_DIV-1, re-check rx_s:
  - rx_s == 0: go to DATA, cnt = 0, bit_idx = 0.
  - rx_s == 1: treat as a glitch, return to IDLE. No outputs change.
- DATA: at cnt == DIVIDER-1, write rx_s into shift[bit_idx] (LSB first) and clear cnt.
  - If bit_idx == 7, go to STOP.
  - Otherwise increment bit_idx.
- STOP: at cnt == DIVIDER-1, sample rx_s.
  - rx_s == 1: rx_data <= shift, rx_valid <= 1, go to IDLE.
  - rx_s == 0: frame_err = 1 for exactly one cycle. rx_data and rx_valid are unchanged; the byte is discarded. Go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s == 1, then go to IDLE. This covers break conditions; a held-low line never produces repeated frames.
- Sample point: every bit is sampled at its nominal centre. The stop bit is sampled 9.5 bit periods (49476 cycles) after the start edge appears on rx_s.
- Latency: rx_valid rises on the cycle after the stop sample. From the rx pin falling edge this is 49476 + 3 cycles (2 sync + 1 register).
- Handshake:
  - rx_ack with rx_valid == 1 clears rx_valid and overrun on the next cycle.
  - rx_ack with rx_valid == 0 is ignored.
- Overrun: a good byte loaded while rx_valid == 1 and no rx_ack in the same cycle:
  - the new byte overwrites rx_data;
  - overrun is set;
  - rx_valid stays 1.
- Simultaneous load and rx_ack: the load wins. rx_valid stays 1, rx_data takes the new byte, overrun is cleared and not set.
- FSM: the state register is 3 bits. Any unused encoding returns to IDLE on the next cycle.
- Reset, at any time including mid-frame:
  - state = IDLE, cnt = 0, bit_idx = 0, shift = 0;
  - rx_data = 8'h00, rx_valid = 0, overrun = 0, frame_err = 0, busy = 0; sync flops = 1.
  - A frame cut by reset is lost. The receiver resyncs on the next falling edge seen after release.
- Back-to-back frames: a start edge in the cycle after STOP exits to IDLE is detected. Inter-frame gap is 0 extra bits.

Decomposition:
- Shared package rs232_pkg, also used by the transmitter:
  - state encodings IDLE/START/DATA/STOP/WAIT_HIGH as 3-bit constants;
  - DIVIDER default 5208 and HALF_DIV 2604;
  - DATA_BITS = 8.
- One sub-module, rs232_sync2: 2-flop synchronizer with reset value 1, reusable for other async inputs such as switches.

Test Plan:
- Send 8'hA5 as 8N1 at exactly 5208 cycles/bit, then idle high.
  -> rx_data = 8'hA5, rx_valid rises 49479 ±1 cycles after the start edge, frame_err never pulses, busy low afterwards.
- Drive a 1000-cycle low glitch on rx while idle.
  -> returns to IDLE at the mid-start check; rx_valid stays 0; busy high for about 2604 cycles only.
- Send 8'h3C with stop bit low, then hold low for 20000 cycles, then release high.
  -> one frame_err pulse; rx_data unchanged; no further frames; busy drops after release.
- Send 8'h11 then 8'h22 back-to-back without rx_ack.
  -> rx_data = 8'h22, rx_valid = 1, overrun = 1. Then pulse rx_ack -> rx_valid = 0, overrun = 0.
- Assert rx_ack in the same cycle as the 8'h55 load while holding 8'h11.
  -> rx_valid stays 1, rx_data = 8'h55, overrun = 0.
- Assert rst for 1 cycle during data bit 4 of 8'hFF, then send 8'h0F cleanly.
  -> all outputs 0 after reset; only 8'h0F is reported; no frame_err.
